// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Sequences one shift or rotate operation over an external, shared,
// combinational barrel shifter. Plain shifts take one shifter pass; rotates
// take two passes (one in each direction) whose results are OR-ed together.
//
// Optional feature:
//   SHIFT_SEQ_ROTATE_EN  defined   -> ROR (100) / ROL (101) supported
//                        undefined -> ROR / ROL report err like any other
//                                     unsupported op; PASS2 is unreachable
//
// Ports:
//   clk          in   1  single clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   start        in   1  request strobe, sampled only while busy=0
//   op           in   3  000 SLL, 001 SRL, 011 SRA, 100 ROR, 101 ROL
//   shamt        in   5  shift / rotate amount
//   data         in  32  operand
//   sh_A         out 32  amount to shared shifter (bits [31:5] always 0)
//   sh_B         out 32  operand to shared shifter
//   sh_ALUFun    out  2  shifter mode: 00 SLL, 01 SRL, 11 SRA
//   sh_C         in  32  shifter result, combinational in the same cycle
//   busy         out  1  high in any state other than IDLE
//   done         out  1  one-cycle completion pulse
//   result       out 32  registered result, held until the next done
//   err          out  1  high with done for an unsupported op, else 0
//   dbg_state_o  out  2  current FSM state (IDLE=0, PASS1=1, PASS2=2, DONE=3)
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0; start is ignored while busy=1. Operands are latched at acceptance,
// so the inputs may change freely afterwards. Completion is signalled by a
// single-cycle done pulse with result/err valid in that cycle.
// ---------------------------------------------------------------------------
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data,
  output logic [31:0] sh_A,
  output logic [31:0] sh_B,
  output logic [1:0]  sh_ALUFun,
  input  logic [31:0] sh_C,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Operation codes
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
`endif

  // Shared shifter modes
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  // Decode of the latched op
  logic        op_ok;      // op is supported in this build
  logic        op_rot;     // op is a rotate (needs a second pass)
  logic [1:0]  mode_p1;    // shifter mode for the first pass
  logic [1:0]  mode_p2;    // shifter mode for the second (rotate) pass

  always_comb begin
    op_ok   = 1'b0;
    op_rot  = 1'b0;
    mode_p1 = SH_SLL;
    mode_p2 = SH_SLL;
    case (op_q)
      OP_SLL: begin op_ok = 1'b1; mode_p1 = SH_SLL; end
      OP_SRL: begin op_ok = 1'b1; mode_p1 = SH_SRL; end
      OP_SRA: begin op_ok = 1'b1; mode_p1 = SH_SRA; end
`ifdef SHIFT_SEQ_ROTATE_EN
      // ROR = (x >> n) | (x << (32-n)); ROL = (x << n) | (x >> (32-n))
      OP_ROR: begin op_ok = 1'b1; op_rot = 1'b1; mode_p1 = SH_SRL; mode_p2 = SH_SLL; end
      OP_ROL: begin op_ok = 1'b1; op_rot = 1'b1; mode_p1 = SH_SLL; mode_p2 = SH_SRL; end
`endif
      default: begin op_ok = 1'b0; end
    endcase
  end

  // Shared shifter drive: only PASS1/PASS2 of a supported op use it.
  always_comb begin
    sh_A      = 32'h0;
    sh_B      = 32'h0;
    sh_ALUFun = SH_SLL;
    case (state_q)
      PASS1: begin
        if (op_ok) begin
          sh_A      = {27'h0, shamt_q};
          sh_B      = data_q;
          sh_ALUFun = mode_p1;
        end
      end
      PASS2: begin
        if (op_rot) begin
          // (32 - shamt) mod 32 is the 5-bit two's complement of shamt
          sh_A      = {27'h0, 5'd0 - shamt_q};
          sh_B      = data_q;
          sh_ALUFun = mode_p2;
        end
      end
      default: begin end
    endcase
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    data_d   = data_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          shamt_d = shamt;
          data_d  = data;
          state_d = PASS1;
        end
      end
      PASS1: begin
        // Unsupported ops bypass the shifter and pass the operand through.
        acc_d = op_ok ? sh_C : data_q;
        // A rotate by zero is complete after the first pass.
        if (op_rot && (shamt_q != 5'd0)) begin
          state_d = PASS2;
        end else begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      PASS2: begin
        acc_d    = acc_q | sh_C;
        result_d = acc_d;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 3'h0;
      shamt_q  <= 5'h0;
      data_q   <= 32'h0;
      acc_q    <= 32'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = (state_q == DONE) && !op_ok;
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL provide port start, input, 1, request strobe; sampled only when busy=0.
REQ-004 SHALL provide port op, input, 3, operation: 000 SLL, 001 SRL, 011 SRA, 100 ROR, 101 ROL; others unsupported.
REQ-005 SHALL provide port shamt, input, 5, shift/rotate amount.
REQ-006 SHALL provide port data, input, 32, operand.
REQ-007 SHALL provide port sh_A, output, 32, amount to shared shifter; bits [31:5] always 0.
REQ-008 SHALL provide port sh_B, output, 32, operand to shared shifter.
REQ-009 SHALL provide port sh_ALUFun, output, 2, shifter mode: 00 SLL, 01 SRL, 11 SRA.
REQ-010 SHALL provide port sh_C, input, 32, combinational shifter result, same cycle.
REQ-011 SHALL provide port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL provide port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL provide port result, output, 32, registered result; held until next done.
REQ-014 SHALL provide port err, output, 1, valid with done; high for an unsupported op.

Function
REQ-015 SHALL implement FSM states IDLE, PASS1, PASS2, DONE.
REQ-016 IDLE with start=1 SHALL latch op, shamt, data and go to PASS1; start while busy SHALL be ignored.
REQ-017 PASS1 SHALL drive sh_B=latched data and sh_A=shamt; mode SLL/SRL/SRA per op, SRL for ROR, SLL for ROL; sh_C captured into accumulator.
REQ-018 PASS1 exit SHALL go to PASS2 for ROR/ROL with shamt!=0, else to DONE.
REQ-019 PASS2 SHALL drive sh_B=latched data, sh_A=(32-shamt) mod 32, opposite direction (SLL for ROR, SRL for ROL); accumulator <= accumulator | sh_C; go to DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, with result=accumulator; go to IDLE.
REQ-021 Unsupported op SHALL skip shifting: PASS1 captures data unchanged, DONE gives result=data, err=1.
REQ-022 Latency: start accepted at cycle T; done at T+2 (single pass) or T+3 (rotate); new start accepted from T+3 / T+4.
REQ-023 In IDLE and DONE, sh_A, sh_B, sh_ALUFun SHALL be 0.
REQ-024 err SHALL be 0 whenever done=0.

Reset
REQ-025 Reset SHALL force IDLE; busy=0, done=0, err=0, result=0, accumulator=0, latched operands=0.
REQ-026 Reset mid-operation (PASS1/PASS2/DONE) SHALL abort with no done pulse; the operation is discarded.
REQ-027 Reset has priority over start in the same cycle.

Configuration
REQ-028 Macro SHIFT_SEQ_ROTATE_EN defined: ROR/ROL supported per REQ-017..019.
REQ-029 Macro undefined: 100/101 SHALL be unsupported (REQ-021), PASS2 unreachable and removable.

Verification
REQ-030 SLL data=0x00000001 shamt=4 start at T -> done at T+2, result=0x00000010, err=0.
REQ-031 SRA data=0x80000000 shamt=31 -> result=0xFFFFFFFF at T+2; SRL same -> 0x00000001.
REQ-032 ROR data=0x000000F1 shamt=4 -> PASS2 sh_A=28, SLL; result=0x1000000F at T+3; ROL data=0x80000001 shamt=0 -> result=0x80000001 at T+2.
REQ-033 start pulsed at T+1 and T+2 during a rotate -> ignored, single done at T+3; reset at T+2 -> next cycle busy=0, done=0, result=0, no done.
REQ-034 op=010 data=0x12345678 -> done at T+2, err=1, result=0x12345678; macro undefined, ROR -> err=1, result=data.
